// File: rtl/pulse_stretch.sv
// Pulse stretcher: turns single-cycle event pulses into fixed-width level
// pulses separated by a guaranteed low gap. Events that arrive while a pulse
// is being shown wait in a saturating counter, so each one gets its own pulse.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | nothing to show, y=0, pend_cnt=0
// ST_HIGH  | showing a pulse, y=1 for HOLD cycles
// ST_GAP   | mandatory low time, y=0 for GAP cycles, then next pulse or idle
module pulse_stretch #(
  parameter int HOLD   = 4,
  parameter int GAP    = 2,
  parameter int PEND_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p,
  output logic              y,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              ovf
);

  localparam int MAX_HG = (HOLD > GAP) ? HOLD : GAP;
  localparam int TW     = $clog2(MAX_HG) + 1;

  // The timer counts down to zero; a state lasting N cycles loads N-1.
  localparam logic [TW-1:0]     HOLD_LD  = TW'(HOLD - 1);
  localparam logic [TW-1:0]     GAP_LD   = TW'(GAP - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [TW-1:0]     timer, timer_nxt;
  logic [PEND_W-1:0] pend_nxt;
  logic              ovf_nxt;
  logic              tc;

  assign tc = (timer == '0);

  // State, timer, queue and output registers; outputs follow the next state
  // so y/busy are registered with exactly one edge of latency from p.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      timer    <= '0;
      pend_cnt <= '0;
      ovf      <= 1'b0;
      y        <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      pend_cnt <= pend_nxt;
      ovf      <= ovf_nxt;
      y        <= (state_nxt == ST_HIGH);
      busy     <= (state_nxt != ST_IDLE);
    end
  end

  // Next-state, timer reload/decrement and pending-event bookkeeping.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    pend_nxt  = pend_cnt;
    ovf_nxt   = ovf;

    unique case (state)
      ST_IDLE: begin
        // An event seen in idle is shown immediately and never queued.
        if (p) begin
          state_nxt = ST_HIGH;
          timer_nxt = HOLD_LD;
        end
      end

      ST_HIGH: begin
        if (tc) begin
          state_nxt = ST_GAP;
          timer_nxt = GAP_LD;
        end else begin
          timer_nxt = timer - 1'b1;
        end
        if (p) begin
          if (pend_cnt != PEND_MAX) pend_nxt = pend_cnt + 1'b1;
          else                      ovf_nxt  = 1'b1;
        end
      end

      ST_GAP: begin
        if (tc) begin
          // A live event on the final gap edge is as good as a queued one:
          // with a queued event present the two cancel (net zero), and with
          // an empty queue the live event starts the next pulse directly.
          if ((pend_cnt != '0) || p) begin
            state_nxt = ST_HIGH;
            timer_nxt = HOLD_LD;
            if ((pend_cnt != '0) && !p) pend_nxt = pend_cnt - 1'b1;
          end else begin
            state_nxt = ST_IDLE;
            timer_nxt = '0;
          end
        end else begin
          timer_nxt = timer - 1'b1;
          if (p) begin
            if (pend_cnt != PEND_MAX) pend_nxt = pend_cnt + 1'b1;
            else                      ovf_nxt  = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        timer_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pulse_stretch.sv
// Bench for pulse_stretch. The reference model schedules each accepted event
// as a pulse start time: start = max(event edge, previous start + HOLD + GAP).
// Outputs after edge t follow from those start times by plain interval tests.
module tb_pulse_stretch;

  localparam int HOLD   = 4;
  localparam int GAP    = 2;
  localparam int PEND_W = 2;
  localparam int PMAX   = (1 << PEND_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              p   = 1'b0;
  logic              y, busy, ovf;
  logic [PEND_W-1:0] pend_cnt;

  int checks   = 0;
  int failures = 0;
  int rises    = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  pulse_stretch #(.HOLD(HOLD), .GAP(GAP), .PEND_W(PEND_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .p        (p),
    .y        (y),
    .busy     (busy),
    .pend_cnt (pend_cnt),
    .ovf      (ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int t;
  int starts[$];
  int last_start;
  bit ovf_m;

  function automatic int cnt_gt(input int tt);
    int n = 0;
    foreach (starts[i]) if (starts[i] > tt) n++;
    return n;
  endfunction

  // Advance model time one edge and schedule or drop the sampled event.
  always @(posedge clk or posedge rst) begin : model
    int s;
    if (rst) begin
      starts.delete();
      last_start = -1000;
      ovf_m      = 1'b0;
      t          = 0;
    end else begin
      t++;
      while (starts.size() > 0 && starts[0] + HOLD + GAP <= t) void'(starts.pop_front());
      if (p) begin
        s = (t > last_start + HOLD + GAP) ? t : last_start + HOLD + GAP;
        if (s > t && cnt_gt(t) == PMAX) ovf_m = 1'b1;
        else begin
          starts.push_back(s);
          last_start = s;
        end
      end
    end
  end

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clk) begin : compare
    bit ym, bm;
    if (chk_en && !rst) begin
      ym = 1'b0;
      bm = 1'b0;
      foreach (starts[i]) begin
        if (starts[i] <= t && t < starts[i] + HOLD)       ym = 1'b1;
        if (starts[i] <= t && t < starts[i] + HOLD + GAP) bm = 1'b1;
      end
      chk("model_y", y, ym);
      chk("model_busy", busy, bm);
      chk("model_pend", pend_cnt, cnt_gt(t));
      chk("model_ovf", ovf, ovf_m);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic pv);
    logic py;
    py = y;
    p  = pv;
    @(posedge clk);
    @(negedge clk);
    if (y === 1'b1 && py === 1'b0) rises++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0);
  endtask

  // Single event from idle; edge 0 is the step(1).
  task automatic single_pulse(input string tag);
    step(1'b1);
    idle(3);
    chk({tag, "_y_edge3"}, y, 1);
    step(1'b0);
    chk({tag, "_y_edge4"}, y, 0);
    chk({tag, "_busy_edge4"}, busy, 1);
    idle(2);
    chk({tag, "_busy_edge6"}, busy, 0);
    chk({tag, "_pend_edge6"}, pend_cnt, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_y", y, 0);
    chk("reset_busy", busy, 0);
    chk("reset_pend", pend_cnt, 0);
    chk("reset_ovf", ovf, 0);
    chk_en = 1'b1;
    idle(3);

    // single event
    single_pulse("t1");
    idle(5);

    // events at edges 0 and 2
    step(1'b1);
    step(1'b0);
    step(1'b1);
    chk("t2_pend_edge2", pend_cnt, 1);
    idle(3);
    chk("t2_pend_edge5", pend_cnt, 1);
    chk("t2_y_edge5", y, 0);
    step(1'b0);
    chk("t2_y_edge6", y, 1);
    chk("t2_pend_edge6", pend_cnt, 0);
    idle(3);
    chk("t2_y_edge9", y, 1);
    step(1'b0);
    chk("t2_y_edge10", y, 0);
    idle(2);
    chk("t2_busy_edge12", busy, 0);
    idle(5);

    // queued event plus a live event on the final gap edge
    step(1'b1);
    step(1'b0);
    step(1'b1);
    idle(3);
    step(1'b1);
    chk("t4_y_edge6", y, 1);
    chk("t4_pend_edge6", pend_cnt, 1);
    idle(6);
    chk("t4_y_edge12", y, 1);
    chk("t4_pend_edge12", pend_cnt, 0);
    idle(6);
    chk("t4_busy_edge18", busy, 0);
    idle(5);

    // p held high three cycles from idle
    rises = 0;
    step(1'b1);
    step(1'b1);
    step(1'b1);
    chk("t6_pend_peak", pend_cnt, 2);
    idle(25);
    chk("t6_pulses", rises, 3);

    // saturation: edge 0 then edges 1..5
    rises = 0;
    step(1'b1);
    step(1'b1);
    step(1'b1);
    step(1'b1);
    chk("t3_pend_edge3", pend_cnt, 3);
    chk("t3_ovf_edge3", ovf, 0);
    step(1'b1);
    chk("t3_ovf_edge4", ovf, 1);
    chk("t3_pend_edge4", pend_cnt, 3);
    step(1'b1);
    idle(30);
    chk("t3_pulses", rises, 4);
    chk("t3_ovf_sticky", ovf, 1);

    // asynchronous reset in the middle of a pulse with an event queued
    step(1'b1);
    step(1'b1);
    p = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t5_y_async", y, 0);
    chk("t5_busy_async", busy, 0);
    chk("t5_pend_async", pend_cnt, 0);
    chk("t5_ovf_async", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    single_pulse("t5");

    // randomized traffic at several event densities
    for (int seg = 0; seg < 3; seg++) begin
      int pct;
      pct = (seg == 0) ? 10 : (seg == 1) ? 35 : 80;
      repeat (600) step(($urandom_range(0, 99) < pct) ? 1'b1 : 1'b0);
      idle(25);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
